// File: rtl/ysyx_22040931_lsu_pkg.sv
// Shared definitions for the load/store unit: op encodings, FSM states and beat geometry.
// The memrop/memwop encodings are the ones the decoder emits.
package ysyx_22040931_lsu_pkg;

  localparam int BEAT_BYTES = 8;
  localparam int BEAT_W     = BEAT_BYTES * 8;

  localparam logic [2:0] OP_NONE = 3'b000;

  localparam logic [2:0] OP_LB  = 3'b001;
  localparam logic [2:0] OP_LH  = 3'b010;
  localparam logic [2:0] OP_LW  = 3'b011;
  localparam logic [2:0] OP_LD  = 3'b100;
  localparam logic [2:0] OP_LBU = 3'b101;
  localparam logic [2:0] OP_LHU = 3'b110;
  localparam logic [2:0] OP_LWU = 3'b111;

  localparam logic [2:0] OP_SB = 3'b001;
  localparam logic [2:0] OP_SH = 3'b010;
  localparam logic [2:0] OP_SW = 3'b011;
  localparam logic [2:0] OP_SD = 3'b100;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_RESP = 2'd3
  } lsu_state_e;

  // log2 of the access size in bytes; illegal store ops are caught separately
  function automatic logic [1:0] op_size_log2(input logic       mem_wr,
                                              input logic [2:0] rop,
                                              input logic [2:0] wop);
    logic [2:0] op;
    logic [1:0] sz;
    op = mem_wr ? wop : rop;
    case (op)
      3'b001, 3'b101: sz = 2'd0;
      3'b010, 3'b110: sz = 2'd1;
      3'b011, 3'b111: sz = 2'd2;
      3'b100:         sz = 2'd3;
      default:        sz = 2'd0;
    endcase
    return sz;
  endfunction

endpackage

// File: rtl/ysyx_22040931_lsu_align.sv
// Byte-lane steering for one 8-byte beat: store mask/data placement, load extraction
// and extension, and legality/alignment checks. Purely combinational.
module ysyx_22040931_lsu_align
  import ysyx_22040931_lsu_pkg::*;
(
  input  logic              mem_wr_i,
  input  logic [2:0]        memrop_i,
  input  logic [2:0]        memwop_i,
  input  logic [2:0]        off_i,
  input  logic [BEAT_W-1:0] wdata_i,
  input  logic [BEAT_W-1:0] dmem_rdata_i,
  output logic [7:0]        wmask_o,
  output logic [BEAT_W-1:0] wdata_o,
  output logic [BEAT_W-1:0] rdata_o,
  output logic              misalign_o,
  output logic              illegal_o
);

  logic [1:0]        size_log2;
  logic [7:0]        base_mask;
  logic [5:0]        shamt;
  logic [BEAT_W-1:0] sh;

  // Lane placement, extension and access checks
  always_comb begin
    size_log2 = op_size_log2(mem_wr_i, memrop_i, memwop_i);
    shamt     = {off_i, 3'b000};
    illegal_o = mem_wr_i ? ((memwop_i == OP_NONE) || (memwop_i > OP_SD))
                         : (memrop_i == OP_NONE);
    case (size_log2)
      2'd0:    begin base_mask = 8'h01; misalign_o = 1'b0;                end
      2'd1:    begin base_mask = 8'h03; misalign_o = off_i[0];            end
      2'd2:    begin base_mask = 8'h0F; misalign_o = (off_i[1:0] != 2'd0); end
      2'd3:    begin base_mask = 8'hFF; misalign_o = (off_i != 3'd0);      end
      default: begin base_mask = 8'h00; misalign_o = 1'b0;                end
    endcase
    wmask_o = base_mask << off_i;
    wdata_o = wdata_i << shamt;
    sh      = dmem_rdata_i >> shamt;
    case (memrop_i)
      OP_LB:   rdata_o = {{56{sh[7]}},  sh[7:0]};
      OP_LH:   rdata_o = {{48{sh[15]}}, sh[15:0]};
      OP_LW:   rdata_o = {{32{sh[31]}}, sh[31:0]};
      OP_LD:   rdata_o = sh;
      OP_LBU:  rdata_o = {56'd0, sh[7:0]};
      OP_LHU:  rdata_o = {48'd0, sh[15:0]};
      OP_LWU:  rdata_o = {32'd0, sh[31:0]};
      default: rdata_o = {BEAT_W{1'b0}};
    endcase
  end

endmodule

// File: rtl/ysyx_22040931_lsu.sv
// Load/store unit: accepts one access at a time, checks it, drives a single dmem
// transaction and returns an extended load result with a one-cycle completion pulse.
module ysyx_22040931_lsu
  import ysyx_22040931_lsu_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 64
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              mem_ena_i,
  input  logic              mem_wr_i,
  input  logic [2:0]        memrop_i,
  input  logic [2:0]        memwop_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic              resp_valid_o,
  output logic [DATA_W-1:0] rdata_o,
  output logic              err_o,
  output logic              dmem_req_valid_o,
  input  logic              dmem_req_ready_i,
  output logic [ADDR_W-1:0] dmem_addr_o,
  output logic              dmem_we_o,
  output logic [7:0]        dmem_wmask_o,
  output logic [BEAT_W-1:0] dmem_wdata_o,
  input  logic              dmem_resp_valid_i,
  input  logic [BEAT_W-1:0] dmem_rdata_i
);

  lsu_state_e state_q, state_d;

  logic              mem_wr_q;
  logic [2:0]        memrop_q, memwop_q, off_q;
  logic [ADDR_W-1:0] dmem_addr_q;
  logic              dmem_we_q;
  logic [7:0]        dmem_wmask_q;
  logic [BEAT_W-1:0] dmem_wdata_q;
  logic [DATA_W-1:0] rdata_q;
  logic              err_q;

  logic              idle, accept, go_req;
  logic              al_wr;
  logic [2:0]        al_rop, al_wop, al_off;
  logic [7:0]        al_wmask;
  logic [BEAT_W-1:0] al_wdata, al_rdata;
  logic              al_misalign, al_illegal;

  // In IDLE the checker looks at the incoming request; afterwards at the latched one
  assign idle   = (state_q == ST_IDLE);
  assign al_wr  = idle ? mem_wr_i     : mem_wr_q;
  assign al_rop = idle ? memrop_i     : memrop_q;
  assign al_wop = idle ? memwop_i     : memwop_q;
  assign al_off = idle ? addr_i[2:0]  : off_q;

  ysyx_22040931_lsu_align u_align (
    .mem_wr_i     (al_wr),
    .memrop_i     (al_rop),
    .memwop_i     (al_wop),
    .off_i        (al_off),
    .wdata_i      (wdata_i),
    .dmem_rdata_i (dmem_rdata_i),
    .wmask_o      (al_wmask),
    .wdata_o      (al_wdata),
    .rdata_o      (al_rdata),
    .misalign_o   (al_misalign),
    .illegal_o    (al_illegal)
  );

  assign accept = req_valid_i && idle;
  assign go_req = accept && mem_ena_i && !al_illegal && !al_misalign;

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: state_d = accept ? (go_req ? ST_REQ : ST_RESP) : ST_IDLE;
      ST_REQ:  state_d = dmem_req_ready_i  ? ST_WAIT : ST_REQ;
      ST_WAIT: state_d = dmem_resp_valid_i ? ST_RESP : ST_WAIT;
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Request latches, dmem request fields and response data
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mem_wr_q     <= 1'b0;
      memrop_q     <= 3'd0;
      memwop_q     <= 3'd0;
      off_q        <= 3'd0;
      dmem_addr_q  <= '0;
      dmem_we_q    <= 1'b0;
      dmem_wmask_q <= 8'h00;
      dmem_wdata_q <= '0;
      rdata_q      <= '0;
      err_q        <= 1'b0;
    end else if (accept) begin
      mem_wr_q     <= mem_wr_i;
      memrop_q     <= memrop_i;
      memwop_q     <= memwop_i;
      off_q        <= addr_i[2:0];
      dmem_addr_q  <= {addr_i[ADDR_W-1:3], 3'b000};
      dmem_we_q    <= go_req && mem_wr_i;
      dmem_wmask_q <= al_wmask;
      dmem_wdata_q <= al_wdata;
      err_q        <= mem_ena_i && (al_illegal || al_misalign);
      rdata_q      <= go_req ? rdata_q : '0;
    end else if ((state_q == ST_REQ) && dmem_req_ready_i) begin
      dmem_we_q    <= 1'b0;
    end else if ((state_q == ST_WAIT) && dmem_resp_valid_i) begin
      rdata_q      <= mem_wr_q ? '0 : al_rdata;
      err_q        <= 1'b0;
    end
  end

  assign req_ready_o      = idle;
  assign resp_valid_o     = (state_q == ST_RESP);
  assign dmem_req_valid_o = (state_q == ST_REQ);
  assign rdata_o          = rdata_q;
  assign err_o            = err_q;
  assign dmem_addr_o      = dmem_addr_q;
  assign dmem_we_o        = dmem_we_q;
  assign dmem_wmask_o     = dmem_wmask_q;
  assign dmem_wdata_o     = dmem_wdata_q;

endmodule
